fc_layer: RTL and testbench

Fully-connected layer stage, directly downstream of the max-pooling stage in the LeNet datapath. Reads the flattened pooled feature map, per-neuron weights and biases from DRAM through the shared single-port request interface. Computes one signed fixed-point dot product per output neuron and writes the saturated results back to DRAM. Pulses `done` so the layer sequencer can advance its stage counter.

---
 rtl/lenet_pkg.sv | 25 ++
 rtl/fc_mac.sv | 63 ++++++
 rtl/fc_layer.sv | 159 +++++++++++++++
 tb/tb_fc_layer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lenet_pkg.sv
// Shared LeNet datapath constants: fixed-point format, DRAM memory map and fc_layer states.
package lenet_pkg;

    localparam int unsigned FRAC_BITS = 16;

    // DRAM word addresses shared by the conv, relu, pool and fc stages
    localparam int unsigned FMAP_BASE = 0;
    localparam int unsigned WGT_BASE  = 1024;
    localparam int unsigned BIAS_BASE = 50000;
    localparam int unsigned OUT_BASE  = 51000;

    typedef enum logic [3:0] {
        StIdle,
        StRdB,
        StWtB,
        StRdF,
        StWtF,
        StRdW,
        StWtW,
        StMac,
        StWr,
        StDone
    } fc_state_e;

endpackage

// File: rtl/fc_mac.sv
// Signed fixed-point multiply-accumulate with bias preload and saturating readout.
module fc_mac #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FRAC_BITS  = 16
) (
    input  logic                         clk,
    input  logic                         srst,
    input  logic                         clear,
    input  logic                         load_bias,
    input  logic                         accumulate,
    input  logic signed [DATA_WIDTH-1:0] bias,
    input  logic signed [DATA_WIDTH-1:0] feature,
    input  logic signed [DATA_WIDTH-1:0] weight,
    output logic signed [DATA_WIDTH-1:0] result
);

    localparam int unsigned AccW  = DATA_WIDTH + 8;
    localparam int unsigned ProdW = 2 * DATA_WIDTH;
    localparam int unsigned SumW  = ProdW + 2;

    logic signed [ProdW-1:0] prod, prod_sh;
    logic signed [SumW-1:0]  sum, sum_max, sum_min;
    logic signed [AccW-1:0]  acc, acc_next, out_max, out_min;

    always_comb begin
        prod    = ProdW'(feature) * ProdW'(weight);
        prod_sh = prod >>> FRAC_BITS;
        sum     = SumW'(acc) + SumW'(prod_sh);
        sum_max = SumW'({1'b0, {(AccW-1){1'b1}}});
        sum_min = ~sum_max;
        // Clamp at the accumulator range so a huge partial sum cannot wrap sign
        if (sum > sum_max) begin
            acc_next = {1'b0, {(AccW-1){1'b1}}};
        end else if (sum < sum_min) begin
            acc_next = {1'b1, {(AccW-1){1'b0}}};
        end else begin
            acc_next = sum[AccW-1:0];
        end
    end

    always_comb begin
        out_max = AccW'({1'b0, {(DATA_WIDTH-1){1'b1}}});
        out_min = ~out_max;
        if (acc > out_max) begin
            result = out_max[DATA_WIDTH-1:0];
        end else if (acc < out_min) begin
            result = out_min[DATA_WIDTH-1:0];
        end else begin
            result = acc[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (srst || clear) begin
            acc <= '0;
        end else if (load_bias) begin
            acc <= AccW'(bias);
        end else if (accumulate) begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/fc_layer.sv
// Fully-connected layer: streams bias, features and weights from DRAM, one neuron at a time,
// and writes each saturated dot product back.
module fc_layer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 18,
    parameter int unsigned FRAC_BITS  = lenet_pkg::FRAC_BITS,
    parameter int unsigned IN_NUM     = 400,
    parameter int unsigned OUT_NUM    = 120,
    parameter int unsigned FMAP_BASE  = lenet_pkg::FMAP_BASE,
    parameter int unsigned WGT_BASE   = lenet_pkg::WGT_BASE,
    parameter int unsigned BIAS_BASE  = lenet_pkg::BIAS_BASE,
    parameter int unsigned OUT_BASE   = lenet_pkg::OUT_BASE
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  enable,
    input  logic                  dram_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [ADDR_WIDTH-1:0] addr_in,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic                  dram_en_rd,
    output logic                  dram_en_wr,
    output logic                  done
);

    import lenet_pkg::*;

    fc_state_e             state;
    logic [ADDR_WIDTH-1:0] o_cnt, i_cnt, w_ptr;
    logic [DATA_WIDTH-1:0] feat_q, wgt_q, mac_result;
    logic                  got_q;
    logic                  mac_clear, mac_load, mac_acc;

    assign mac_clear = (state == StIdle);
    assign mac_load  = (state == StWtB) && dram_valid && !got_q;
    assign mac_acc   = (state == StMac) && enable;

    fc_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_BITS  (FRAC_BITS)
    ) u_mac (
        .clk        (clk),
        .srst       (srst),
        .clear      (mac_clear),
        .load_bias  (mac_load),
        .accumulate (mac_acc),
        .bias       (data_in),
        .feature    (feat_q),
        .weight     (wgt_q),
        .result     (mac_result)
    );

    // got_q remembers a read that completed while enable was low
    always_ff @(posedge clk) begin
        if (srst) begin
            state      <= StIdle;
            o_cnt      <= '0;
            i_cnt      <= '0;
            w_ptr      <= '0;
            feat_q     <= '0;
            wgt_q      <= '0;
            got_q      <= 1'b0;
            dram_en_rd <= 1'b0;
            dram_en_wr <= 1'b0;
            addr_in    <= '0;
            addr_out   <= '0;
            data_out   <= '0;
            done       <= 1'b0;
        end else begin
            dram_en_rd <= 1'b0;
            dram_en_wr <= 1'b0;
            addr_in    <= '0;
            addr_out   <= '0;
            data_out   <= '0;
            done       <= 1'b0;
            case (state)
                StIdle: if (enable) begin
                    o_cnt <= '0;
                    i_cnt <= '0;
                    w_ptr <= ADDR_WIDTH'(WGT_BASE);
                    state <= StRdB;
                end
                StRdB: if (enable) begin
                    dram_en_rd <= 1'b1;
                    addr_in    <= ADDR_WIDTH'(BIAS_BASE) + o_cnt;
                    state      <= StWtB;
                end
                StWtB: if (dram_valid || got_q) begin
                    if (enable) begin
                        got_q <= 1'b0;
                        state <= StRdF;
                    end else begin
                        got_q <= 1'b1;
                    end
                end
                StRdF: if (enable) begin
                    dram_en_rd <= 1'b1;
                    addr_in    <= ADDR_WIDTH'(FMAP_BASE) + i_cnt;
                    state      <= StWtF;
                end
                StWtF: begin
                    if (dram_valid && !got_q) feat_q <= data_in;
                    if (dram_valid || got_q) begin
                        if (enable) begin
                            got_q <= 1'b0;
                            state <= StRdW;
                        end else begin
                            got_q <= 1'b1;
                        end
                    end
                end
                StRdW: if (enable) begin
                    dram_en_rd <= 1'b1;
                    addr_in    <= w_ptr;
                    w_ptr      <= w_ptr + 1'b1;
                    state      <= StWtW;
                end
                StWtW: begin
                    if (dram_valid && !got_q) wgt_q <= data_in;
                    if (dram_valid || got_q) begin
                        if (enable) begin
                            got_q <= 1'b0;
                            state <= StMac;
                        end else begin
                            got_q <= 1'b1;
                        end
                    end
                end
                StMac: if (enable) begin
                    if (i_cnt == ADDR_WIDTH'(IN_NUM - 1)) begin
                        state <= StWr;
                    end else begin
                        i_cnt <= i_cnt + 1'b1;
                        state <= StRdF;
                    end
                end
                StWr: if (enable) begin
                    dram_en_wr <= 1'b1;
                    addr_out   <= ADDR_WIDTH'(OUT_BASE) + o_cnt;
                    data_out   <= mac_result;
                    if (o_cnt == ADDR_WIDTH'(OUT_NUM - 1)) begin
                        state <= StDone;
                    end else begin
                        o_cnt <= o_cnt + 1'b1;
                        i_cnt <= '0;
                        state <= StRdB;
                    end
                end
                StDone: begin
                    done  <= 1'b1;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fc_layer.sv
// Bench for fc_layer: DRAM responder, write scoreboard and a scaled address-sweep instance.
module tb_fc_layer;

    localparam int DW = 32;
    localparam int AW = 18;
    localparam int IN_N = 4;
    localparam int OUT_N = 2;
    localparam int BIG_IN = 40;
    localparam int BIG_OUT = 12;
    localparam int FB = 0;
    localparam int WB = 1024;
    localparam int BB = 50000;
    localparam int OB = 51000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          srst, enable, dram_valid;
    logic [DW-1:0] data_in, data_out;
    logic [AW-1:0] addr_in, addr_out;
    logic          dram_en_rd, dram_en_wr, done;

    logic          b_enable, b_valid;
    logic [DW-1:0] b_data_in, b_data_out;
    logic [AW-1:0] b_addr_in, b_addr_out;
    logic          b_rd, b_wr, b_done;

    fc_layer #(
        .IN_NUM  (IN_N),
        .OUT_NUM (OUT_N)
    ) dut (
        .clk        (clk),
        .srst       (srst),
        .enable     (enable),
        .dram_valid (dram_valid),
        .data_in    (data_in),
        .data_out   (data_out),
        .addr_in    (addr_in),
        .addr_out   (addr_out),
        .dram_en_rd (dram_en_rd),
        .dram_en_wr (dram_en_wr),
        .done       (done)
    );

    fc_layer #(
        .IN_NUM  (BIG_IN),
        .OUT_NUM (BIG_OUT)
    ) dut_big (
        .clk        (clk),
        .srst       (srst),
        .enable     (b_enable),
        .dram_valid (b_valid),
        .data_in    (b_data_in),
        .data_out   (b_data_out),
        .addr_in    (b_addr_in),
        .addr_out   (b_addr_out),
        .dram_en_rd (b_rd),
        .dram_en_wr (b_wr),
        .done       (b_done)
    );

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] mem [int];
    logic [AW-1:0] exp_addr [$];
    logic [DW-1:0] exp_data [$];
    int  lat_lo = 1, lat_hi = 1;
    int  rd_cnt = 0, vld_cnt = 0;
    logic en_q = 1'b0;
    bit  mon_on = 1'b0;
    bit  done_due = 1'b0;

    always @(posedge clk) en_q <= enable;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic expect_wr(input int a, input logic [DW-1:0] d);
        exp_addr.push_back(AW'(a));
        exp_data.push_back(d);
    endtask

    // DRAM responder for the main instance, one read at a time
    initial begin
        int lat;
        logic [AW-1:0] a;
        dram_valid = 1'b0;
        data_in = '0;
        forever begin
            @(negedge clk);
            if (dram_en_rd) begin
                rd_cnt++;
                a = addr_in;
                lat = $urandom_range(lat_hi, lat_lo);
                for (int k = 0; k < lat; k++) begin
                    @(negedge clk);
                    if (dram_en_rd) check("overlapping_read", 1, 0);
                end
                data_in = mem.exists(int'(a)) ? mem[int'(a)] : '0;
                dram_valid = 1'b1;
                vld_cnt++;
                @(negedge clk);
                dram_valid = 1'b0;
                data_in = '0;
            end
        end
    end

    // Monitor: scoreboard on writes plus per-cycle output invariants
    initial begin
        bit due_n;
        forever begin
            @(negedge clk);
            due_n = 1'b0;
            if (mon_on) begin
                check("output_idle_zero",
                      64'((dram_en_rd && dram_en_wr) || (!dram_en_rd && addr_in != 0) ||
                          (!dram_en_wr && (addr_out != 0 || data_out != 0))), 0);
                if ((dram_en_rd || dram_en_wr) && !en_q) check("req_while_disabled", 1, 0);
                if (dram_en_wr) begin
                    if (exp_addr.size() == 0) begin
                        check("unexpected_write", 64'(addr_out), 0);
                    end else begin
                        check("wr_addr", 64'(addr_out), 64'(exp_addr.pop_front()));
                        check("wr_data", 64'(data_out), 64'(exp_data.pop_front()));
                    end
                    due_n = (addr_out == AW'(OB + OUT_N - 1));
                end
                if (done || done_due) check("done_after_last_wr", 64'(done), 64'(done_due));
            end
            done_due = due_n;
        end
    end

    task automatic run(input int lo, input int hi, input bit gaps, input string name);
        int  n = 0;
        bit  seen = 1'b0;
        lat_lo = lo;
        lat_hi = hi;
        while (!seen && n < 20000) begin
            @(negedge clk);
            n++;
            if (done) begin
                seen = 1'b1;
                enable = 1'b0;
            end else begin
                enable = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
        end
        enable = 1'b0;
        check({name, "_done_seen"}, 64'(seen), 1);
        repeat (3) @(negedge clk);
        check({name, "_all_writes"}, 64'(exp_addr.size()), 0);
    endtask

    task automatic load_basic();
        mem.delete();
        mem[FB + 0] = 32'h0001_0000;
        mem[FB + 1] = 32'h0002_0000;
        mem[FB + 2] = 32'hFFFF_0000;
        mem[FB + 3] = 32'h0000_8000;
        for (int k = 0; k < 4; k++) mem[WB + k] = 32'h0000_8000;
        mem[WB + 4] = 32'h0001_0000;
        mem[BB + 0] = 32'h0000_4000;
        mem[BB + 1] = 32'hFFFD_0000;
    endtask

    task automatic expect_basic();
        expect_wr(OB, 32'h0001_8000);      // 0.25 + 0.5*(1 + 2 - 1 + 0.5) = 1.5
        expect_wr(OB + 1, 32'hFFFE_0000);  // -3 + 1*1 = -2
    endtask

    // Sweep instance: fixed latency 1, tracks last weight address and write order
    logic b_pend;
    int   b_wr_cnt = 0, b_done_cnt = 0, b_last_w = -1;
    initial begin
        b_valid = 1'b0;
        b_pend = 1'b0;
        b_data_in = 32'h0001_0000;
        forever begin
            @(negedge clk);
            b_valid = b_pend;
            b_pend = b_rd;
            if (b_rd && b_addr_in >= AW'(WB) && b_addr_in < AW'(BB)) b_last_w = int'(b_addr_in);
            if (b_wr) begin
                check("sweep_wr_addr", 64'(b_addr_out), 64'(OB + b_wr_cnt));
                b_wr_cnt++;
            end
            if (b_done) b_done_cnt++;
        end
    end

    initial begin
        int n;
        int rc;
        bit hit;
        srst = 1'b1;
        enable = 1'b0;
        b_enable = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {29'd0, dram_en_rd, dram_en_wr, done, addr_in, addr_out},
              64'd0);
        check("reset_data_out", 64'(data_out), 0);
        srst = 1'b0;
        mon_on = 1'b1;

        load_basic();
        expect_basic();
        run(1, 1, 1'b0, "basic");

        mem.delete();
        for (int k = 0; k < 4; k++) begin
            mem[FB + k] = 32'h7FFF_0000;
            mem[WB + k] = 32'h7FFF_0000;
            mem[WB + 4 + k] = 32'h8001_0000;
        end
        expect_wr(OB, 32'h7FFF_FFFF);
        expect_wr(OB + 1, 32'h8000_0000);
        run(1, 2, 1'b0, "saturate");

        load_basic();
        expect_basic();
        run(1, 5, 1'b1, "gaps");
        check("one_valid_per_read", 64'(rd_cnt), 64'(vld_cnt));

        mem.delete();
        mem[FB] = 32'hFFFF_FFFF;
        mem[WB] = 32'h0000_8000;
        expect_wr(OB, 32'hFFFF_FFFF);
        expect_wr(OB + 1, 32'h0000_0000);
        run(1, 1, 1'b0, "neg_trunc");

        // Reset while neuron 0 waits on its first weight
        load_basic();
        lat_lo = 4;
        lat_hi = 4;
        n = 0;
        hit = 1'b0;
        while (!hit && n < 1000) begin
            @(negedge clk);
            n++;
            enable = 1'b1;
            if (dram_en_rd && addr_in == AW'(WB)) hit = 1'b1;
        end
        check("rst_reached_wt_w", 64'(hit), 1);
        srst = 1'b1;
        @(negedge clk);
        check("rst_mid_outputs", {29'd0, dram_en_rd, dram_en_wr, done, addr_in, addr_out}, 0);
        check("rst_mid_data_out", 64'(data_out), 0);
        srst = 1'b0;
        enable = 1'b0;
        rc = rd_cnt;
        repeat (12) @(negedge clk);
        check("rst_no_new_reads", 64'(rd_cnt), 64'(rc));
        expect_basic();
        run(1, 1, 1'b0, "after_reset");
        check("reads_all_answered", 64'(rd_cnt), 64'(vld_cnt));

        n = 0;
        hit = 1'b0;
        while (!hit && n < 20000) begin
            @(negedge clk);
            n++;
            if (b_done) begin
                hit = 1'b1;
                b_enable = 1'b0;
            end else begin
                b_enable = 1'b1;
            end
        end
        b_enable = 1'b0;
        repeat (5) @(negedge clk);
        check("sweep_done_seen", 64'(hit), 1);
        check("sweep_last_weight", 64'(b_last_w), 64'(WB + BIG_IN * BIG_OUT - 1));
        check("sweep_writes", 64'(b_wr_cnt), 64'(BIG_OUT));
        check("sweep_done_once", 64'(b_done_cnt), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
